// File: rtl/cycle_sequencer_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
package cycle_sequencer_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned STATE_W = 3;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    // A load that also claims to store is executed as a plain load.
    function automatic logic store_only(input logic ld, input logic st);
        return st & ~ld;
    endfunction

endpackage

// File: rtl/cycle_sequencer_retire_counter.sv
// Retired-instruction counter: synchronous clear, increment enable, wraps at 2^W.
module retire_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear has priority over increment.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control with
// registered datapath enables, PC register and retired-instruction counter.
// Optional single-step mode: define CYCLE_SEQUENCER_STEP_EN to add port step;
// every retire then halts and step=1 in HALT resumes for one instruction.
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             writes_reg,
`ifdef CYCLE_SEQUENCER_STEP_EN
    input  logic             step,
`endif
    input  logic [31:0]      pc_next_in,
    output logic [31:0]      pc,
    output logic             ir_en,
    output logic             reg_we,
    output logic             mem_we,
    output logic             pc_en,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t cur_state;
    state_t nxt_state;
    logic   stop_c;
    logic   resume_c;

    assign state = cur_state;

    // Stop/resume qualifiers; step mode halts after every retire.
`ifdef CYCLE_SEQUENCER_STEP_EN
    assign stop_c   = 1'b1;
    assign resume_c = start | step;
`else
    assign stop_c   = halt_req;
    assign resume_c = start;
`endif

    // Next-state decode; pc_en being high marks the retire cycle.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:    if (start) nxt_state = FETCH;
            FETCH:   nxt_state = DECODE;
            DECODE:  nxt_state = EXEC;
            EXEC:    nxt_state = (is_load | is_store) ? MEM : WB;
            MEM: begin
                if (pc_en) nxt_state = stop_c ? HALT : FETCH;
                else       nxt_state = WB;
            end
            WB:      nxt_state = stop_c ? HALT : FETCH;
            HALT:    if (resume_c) nxt_state = FETCH;
            default: nxt_state = IDLE;
        endcase
    end

    // State, PC and enables registered from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= IDLE;
            pc        <= RESET_PC;
            ir_en     <= 1'b0;
            reg_we    <= 1'b0;
            mem_we    <= 1'b0;
            pc_en     <= 1'b0;
            halted    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (pc_en) begin
                pc <= pc_next_in;
            end
            ir_en  <= (nxt_state == DECODE);
            mem_we <= (nxt_state == MEM) && store_only(is_load, is_store);
            reg_we <= (nxt_state == WB) && writes_reg;
            pc_en  <= (nxt_state == WB) ||
                      ((nxt_state == MEM) && store_only(is_load, is_store));
            halted <= (nxt_state == HALT);
        end
    end

    // Retire count advances on every pc_en cycle.
    retire_counter #(
        .W (CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .clr   (rst),
        .inc   (pc_en),
        .count (retired)
    );

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, leave IDLE/HALT and begin fetching.
REQ-006 SHALL have port halt_req, input, 1, request a stop at the next instruction boundary.
REQ-007 SHALL have port is_load, input, 1, decoded instruction reads data memory.
REQ-008 SHALL have port is_store, input, 1, decoded instruction writes data memory.
REQ-009 SHALL have port writes_reg, input, 1, decoded instruction writes the register file.
REQ-010 SHALL have port pc_next_in, input, 32, next PC from the branch module.
REQ-011 SHALL have port pc, output, 32, current PC to instruction ROM and branch module.
REQ-012 SHALL have ports ir_en, reg_we, mem_we, pc_en, output, 1 each, single-cycle enable pulses to the datapath.
REQ-013 SHALL have ports state, output, 3, current state encoding; halted, output, 1, high in HALT.
REQ-014 SHALL have port retired, output, CNT_W, count of retired instructions.

Function
REQ-015 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-016 IDLE: start=1 -> FETCH; otherwise stay; all enables 0.
REQ-017 FETCH: pc drives the synchronous ROM; always -> DECODE.
REQ-018 DECODE: ir_en=1 (ROM data valid one cycle after address); -> EXEC.
REQ-019 EXEC: is_load or is_store -> MEM; else -> WB.
REQ-020 MEM: mem_we=is_store; store retires here; load -> WB (RAM data valid next cycle).
REQ-021 WB: reg_we=writes_reg; instruction retires here.
REQ-022 On retire: pc_en=1, pc <= pc_next_in, retired <= retired+1 (wraps modulo 2^CNT_W); next state HALT if halt_req=1, else FETCH.
REQ-023 Cycles per instruction SHALL be exactly 4 for ALU, branch and store, and 5 for load.
REQ-024 HALT: halted=1, pc and retired held; start=1 -> FETCH, resuming at the held pc.
REQ-025 start SHALL be ignored outside IDLE and HALT; halt_req SHALL be sampled only in the retire cycle.
REQ-026 is_load and is_store both high SHALL be treated as a load (mem_we=0).
REQ-027 Enables SHALL be Moore-decoded from state plus the decode inputs, and SHALL never assert in IDLE, FETCH or HALT.

Reset
REQ-028 rst=1 SHALL on the same edge force state=IDLE, pc=RESET_PC, retired=0, halted=0; all enables read 0 in the following cycle.
REQ-029 rst SHALL override every other input and abort any in-flight instruction without a retire.

Configuration
REQ-030 With macro CYCLE_SEQUENCER_STEP_EN defined, an input port step (1 bit) SHALL exist; every retire enters HALT, and step=1 in HALT acts as start.
REQ-031 Without CYCLE_SEQUENCER_STEP_EN, port step SHALL be absent and the sequencer SHALL free-run until halt_req.

Structure
REQ-032 Package cycle_sequencer_pkg SHALL hold the state enum (IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6) and the RESET_PC default.
REQ-033 Sub-module retire_counter (CNT_W-bit, sync clear, increment enable) SHALL implement retired; FSM and PC register SHALL stay in cycle_sequencer.

Verification
REQ-034 Reset, then start pulse, ALU op, pc_next_in=4 -> states 1,2,3,5; pc_en in cycle 4; pc=4; retired=1.
REQ-035 Load with writes_reg=1 -> states FETCH,DECODE,EXEC,MEM,WB; reg_we only in WB; mem_we never asserts; 5 cycles.
REQ-036 Store -> mem_we=1 for exactly 1 cycle in MEM; pc_en in the same cycle; reg_we stays 0; 4 cycles.
REQ-037 halt_req=1 held from DECODE -> HALT after the retire; pc=pc_next_in; later start -> FETCH at that pc.
REQ-038 rst asserted in MEM of a store -> mem_we=0 on the next cycle; state=IDLE; pc=RESET_PC; retired unchanged at 0.
REQ-039 Force retired=2^CNT_W-1 and retire one instruction -> retired=0; with CYCLE_SEQUENCER_STEP_EN, each step pulse yields exactly one retire.
